// File: rtl/sysbus_mem_responder.sv
// rtl/sysbus_mem_responder.sv - system bus memory responder backed by a line store
//
// Serves whole-line (8-beat) writes and reads from a LINE_COUNT x 512-bit store.
// Every accepted header or write beat is acknowledged with a one-cycle pulse on
// bus_reqack. Reads wait READ_LATENCY idle cycles after the header ack, then
// return 8 beats with a valid/ack handshake.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   bus_reqcyc     request/beat valid from initiator
//   bus_reqack     one-cycle accept pulse for a header or write beat
//   bus_req        header: byte address; write phase: data beat
//   bus_reqtag     request tag (bit 12 = write), valid with the header
//   bus_respcyc    read response beat valid
//   bus_respack    initiator accepted the current response beat
//   bus_resp       read response data beat (0 when bus_respcyc = 0)
//   bus_resptag    tag of the read being answered (0 when bus_respcyc = 0)

module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_COUNT     = 64,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int LINE_W = 8 * BUS_DATA_WIDTH;
    localparam int IDX_W  = $clog2(LINE_COUNT);
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);
    localparam int WR_BIT = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRDATA = 2'd1,
        RDWAIT = 2'd2,
        RDRESP = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         beat_cnt;
    logic [2:0]         beat_cnt_nxt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [LAT_W-1:0]   lat_cnt_nxt;
    logic               accept;
    logic               store_we;

    logic [IDX_W-1:0]         line_idx;
    logic [BUS_TAG_WIDTH-1:0] tag_q;
    logic [LINE_W-1:0]        line_buf;
    logic [LINE_W-1:0]        line_merged;
    logic [LINE_W-1:0]        store [LINE_COUNT];

    // A request is only taken when no ack pulse is in flight, so every beat
    // costs at least two cycles and reqcyc during the ack cycle is ignored.
    always_comb begin
        accept = bus_reqcyc && !bus_reqack && (state == IDLE || state == WRDATA);
    end

    // Line buffer with the incoming write beat merged in; lets the last beat
    // go straight into the store on the edge it is accepted.
    always_comb begin
        line_merged = line_buf;
        line_merged[int'(beat_cnt) * BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus_req;
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        lat_cnt_nxt  = lat_cnt;
        store_we     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    beat_cnt_nxt = 3'd0;
                    if (bus_reqtag[WR_BIT]) begin
                        state_nxt = WRDATA;
                    end else begin
                        state_nxt   = RDWAIT;
                        lat_cnt_nxt = LAT_W'(READ_LATENCY);
                    end
                end
            end
            WRDATA: begin
                if (accept) begin
                    if (beat_cnt == 3'd7) begin
                        store_we     = 1'b1;
                        state_nxt    = IDLE;
                        beat_cnt_nxt = 3'd0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 3'd1;
                    end
                end
            end
            RDWAIT: begin
                // Counter loaded at header accept; the extra edge at zero
                // gives READ_LATENCY idle cycles after the ack cycle.
                if (lat_cnt == '0) begin
                    state_nxt    = RDRESP;
                    beat_cnt_nxt = 3'd0;
                end else begin
                    lat_cnt_nxt = lat_cnt - 1'b1;
                end
            end
            RDRESP: begin
                if (bus_respack) begin
                    if (beat_cnt == 3'd7) begin
                        state_nxt    = IDLE;
                        beat_cnt_nxt = 3'd0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beat_cnt   <= 3'd0;
            lat_cnt    <= '0;
            bus_reqack <= 1'b0;
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_cnt_nxt;
            lat_cnt    <= lat_cnt_nxt;
            bus_reqack <= accept;
        end
    end

    // Datapath and store are not reset: the store must survive reset, and a
    // partially received line only ever lives in line_buf.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            line_idx <= bus_req[6 +: IDX_W];
            tag_q    <= bus_reqtag;
        end
        if (state == WRDATA && accept) begin
            line_buf <= line_merged;
        end
        if (state == RDWAIT) begin
            line_buf <= store[line_idx];
        end
        if (store_we && !reset) begin
            store[line_idx] <= line_merged;
        end
    end

    always_comb begin
        bus_respcyc = (state == RDRESP);
        bus_resp    = '0;
        bus_resptag = '0;
        if (bus_respcyc) begin
            bus_resp    = line_buf[int'(beat_cnt) * BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
            bus_resptag = tag_q;
        end
    end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb/tb_sysbus_mem_responder.sv - self-checking bench for sysbus_mem_responder

module tb_sysbus_mem_responder;

    localparam int READ_LATENCY = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_reqcyc;
    logic        bus_reqack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc;
    logic        bus_respack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;

    int checks   = 0;
    int failures = 0;

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH(64),
        .BUS_TAG_WIDTH (13),
        .LINE_COUNT    (64),
        .READ_LATENCY  (READ_LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_reqcyc (bus_reqcyc),
        .bus_reqack (bus_reqack),
        .bus_req    (bus_req),
        .bus_reqtag (bus_reqtag),
        .bus_respcyc(bus_respcyc),
        .bus_respack(bus_respack),
        .bus_resp   (bus_resp),
        .bus_resptag(bus_resptag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [12:0] tag;
        logic [63:0] pat;
        int          stall_beat;
        int          stall_n;
        logic        early_ack;
        logic        hold_req;
    } op_t;

    op_t ops [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_reqack"}, 64'(bus_reqack), 64'd0);
        chk({name, "_respcyc"}, 64'(bus_respcyc), 64'd0);
        chk({name, "_resp"}, bus_resp, 64'd0);
        chk({name, "_resptag"}, 64'(bus_resptag), 64'd0);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [12:0] tag,
                            input logic [63:0] pat, input int nbeats);
        bus_req    = addr;
        bus_reqtag = tag;
        bus_reqcyc = 1'b1;
        @(posedge clk); #1;
        chk("wr_hdr_ack", 64'(bus_reqack), 64'd1);
        for (int b = 0; b < nbeats; b++) begin
            bus_req = pat * 64'(b + 1);
            @(posedge clk); #1;
            chk("wr_gap_noack", 64'(bus_reqack), 64'd0);
            @(posedge clk); #1;
            chk("wr_beat_ack", 64'(bus_reqack), 64'd1);
        end
        if (nbeats == 8) begin
            bus_reqcyc = 1'b0;
            @(posedge clk); #1;
            chk("wr_done_noack", 64'(bus_reqack), 64'd0);
        end
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [12:0] tag,
                           input logic [63:0] pat, input int stall_beat, input int stall_n,
                           input logic early_ack, input logic hold_req,
                           input logic [63:0] h_addr, input logic [12:0] h_tag);
        int n;
        bus_req     = addr;
        bus_reqtag  = tag;
        bus_reqcyc  = 1'b1;
        bus_respack = early_ack;
        @(posedge clk); #1;
        chk("rd_hdr_ack", 64'(bus_reqack), 64'd1);
        if (hold_req) begin
            bus_req    = h_addr;
            bus_reqtag = h_tag;
        end else begin
            bus_reqcyc = 1'b0;
        end
        n = 0;
        while (bus_respcyc !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (hold_req) chk("rd_wait_noack", 64'(bus_reqack), 64'd0);
        end
        chk("rd_latency", 64'(n), 64'(READ_LATENCY + 1));
        for (int b = 0; b < 8; b++) begin
            chk("rd_respcyc", 64'(bus_respcyc), 64'd1);
            chk("rd_data", bus_resp, pat * 64'(b + 1));
            chk("rd_tag", 64'(bus_resptag), 64'(tag));
            if (hold_req) chk("rd_resp_noack", 64'(bus_reqack), 64'd0);
            if (b == stall_beat) begin
                bus_respack = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(posedge clk); #1;
                    chk("rd_stall_data", bus_resp, pat * 64'(b + 1));
                    chk("rd_stall_cyc", 64'(bus_respcyc), 64'd1);
                end
            end
            bus_respack = 1'b1;
            @(posedge clk); #1;
        end
        bus_respack = 1'b0;
        chk("rd_end_respcyc", 64'(bus_respcyc), 64'd0);
        chk("rd_end_resp", bus_resp, 64'd0);
        chk("rd_end_resptag", 64'(bus_resptag), 64'd0);
        if (hold_req) chk("rd_end_noack", 64'(bus_reqack), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //            wr    addr        tag       pat                     stall  n  early hold
        ops[0] = '{1'b1, 64'h40,   13'h1000, 64'h11,                  -1, 0, 1'b0, 1'b0};
        ops[1] = '{1'b0, 64'h40,   13'h0005, 64'h11,                  -1, 0, 1'b0, 1'b0};
        ops[2] = '{1'b0, 64'h40,   13'h0abc, 64'h11,                   3, 5, 1'b0, 1'b0};
        ops[3] = '{1'b0, 64'h1040, 13'h0007, 64'h11,                  -1, 0, 1'b0, 1'b0};
        ops[4] = '{1'b1, 64'h0fc0, 13'h1fff, 64'h1000_0000_0000_0001, -1, 0, 1'b0, 1'b0};
        ops[5] = '{1'b0, 64'h0fff, 13'h0fff, 64'h1000_0000_0000_0001, -1, 0, 1'b1, 1'b0};
        ops[6] = '{1'b0, 64'h40,   13'h0042, 64'h11,                  -1, 0, 1'b0, 1'b1};
        ops[7] = '{1'b1, 64'h80,   13'h1001, 64'h0202_0202_0202_0202, -1, 0, 1'b0, 1'b0};
        ops[8] = '{1'b0, 64'h80,   13'h0001, 64'h0202_0202_0202_0202, -1, 0, 1'b0, 1'b0};

        reset       = 1'b1;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            if (ops[i].wr) begin
                do_write(ops[i].addr, ops[i].tag, ops[i].pat, 8);
            end else if (ops[i].hold_req && i < 8) begin
                do_read(ops[i].addr, ops[i].tag, ops[i].pat, ops[i].stall_beat,
                        ops[i].stall_n, ops[i].early_ack, 1'b1, ops[i+1].addr, ops[i+1].tag);
            end else begin
                do_read(ops[i].addr, ops[i].tag, ops[i].pat, ops[i].stall_beat,
                        ops[i].stall_n, ops[i].early_ack, 1'b0, 64'd0, 13'd0);
            end
        end

        // Reset after beat 4 of a write to line 1: the store must keep the old line.
        do_write(64'h40, 13'h1000, 64'h99, 5);
        bus_reqcyc = 1'b0;
        reset      = 1'b1;
        @(posedge clk); #1;
        chk_idle_outputs("midwr_reset");
        reset = 1'b0;
        @(posedge clk); #1;
        chk_idle_outputs("post_reset");
        do_read(64'h40, 13'h0003, 64'h11, -1, 0, 1'b0, 1'b0, 64'd0, 13'd0);
        do_read(64'h80, 13'h0004, 64'h0202_0202_0202_0202, 7, 2, 1'b0, 1'b0, 64'd0, 13'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
